lsu_wb_stage: RTL and testbench

- Writeback/load-store stage of the CPU pipeline. Sits directly upstream of the register file and is the only driver of its write port (waddr/wdata/we).
- Accepts one retired instruction per handshake from execute: either an ALU result or a load/store.
- Load/store operations run over a req/ack data-memory bus.
- Execute is stalled while a memory access is outstanding.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_align.sv | 61 ++++++
 rtl/lsu_wb_stage.sv | 209 ++++++++++++++++++++
 tb/tb_lsu_wb_stage.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store writeback stage.
// Holds the funct3 size/sign codes, the stage state encoding and a helper
// that folds a funct3 code into an access size (undefined codes act as word).
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Signed and unsigned variants share a size; every other code is a word.
  function automatic size_e f3_size(input logic [2:0] f3);
    size_e sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for the load/store stage (purely combinational).
// Ports:
//   funct3   - access size/sign code
//   addr_lo  - low two address bits (byte offset inside the word)
//   sdata    - store data, right-aligned
//   rdata    - raw load word from the bus
//   be       - byte enables for the access
//   wdata    - store data replicated into every lane of its size
//   ldata    - extracted and sign/zero-extended load data
//   misalign - access is not naturally aligned for its size
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misalign
);

  size_e       size;
  logic        sign_ext;
  logic [31:0] shifted;

  // Bring the addressed byte/half down to bit 0 so extraction is a plain
  // truncate plus extension. Replicating store data into all lanes gives the
  // same result as shifting it into the enabled lane.
  always_comb begin
    size     = f3_size(funct3);
    sign_ext = ~funct3[2];
    shifted  = rdata >> {addr_lo, 3'b000};
    be       = 4'b0000;
    wdata    = 32'h0;
    ldata    = 32'h0;
    misalign = 1'b0;
    case (size)
      SZ_B: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{sdata[7:0]}};
        ldata = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        be       = 4'b0011 << addr_lo;
        wdata    = {2{sdata[15:0]}};
        ldata    = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
        misalign = addr_lo[0];
      end
      default: begin
        // An aligned word has addr_lo == 0, so shifted equals rdata here.
        be       = 4'b1111;
        wdata    = sdata;
        ldata    = shifted;
        misalign = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/lsu_wb_stage.sv
// Writeback / load-store stage: sole driver of the register file write port.
// ALU results are written one cycle after accept; aligned loads/stores run a
// req/ack bus transaction with a timeout, stalling execute meanwhile.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   ex_valid/ex_ready          - handshake from execute
//   ex_rd, ex_result           - destination reg, ALU result / address
//   ex_is_load, ex_is_store    - op kind (both set means store)
//   ex_funct3, ex_sdata        - size/sign code, right-aligned store data
//   mem_req/we/addr/be/wdata   - registered bus request
//   mem_ack, mem_rdata         - bus completion strobe and load word
//   rf_waddr/wdata/we          - register file write port
//   misalign, bus_err          - single-cycle error pulses
module lsu_wb_stage
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_sdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        rf_we,
  output logic        misalign,
  output logic        bus_err
);

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        rf_we_q, rf_we_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic        accept;
  logic        is_mem_op;
  logic [2:0]  al_f3;
  logic [1:0]  al_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_ldata;
  logic        al_mis;

  assign ex_ready  = (state_q == ST_IDLE);
  assign accept    = ex_valid & ex_ready;
  assign is_mem_op = ex_is_load | ex_is_store;

  // One lane unit serves both phases: in IDLE it sizes the incoming op,
  // in MEM it extracts load data using the captured size and offset.
  assign al_f3 = (state_q == ST_IDLE) ? ex_funct3 : f3_q;
  assign al_lo = (state_q == ST_IDLE) ? ex_result[1:0] : addr_lo_q;

  lsu_align u_align (
    .funct3   (al_f3),
    .addr_lo  (al_lo),
    .sdata    (ex_sdata),
    .rdata    (mem_rdata),
    .be       (al_be),
    .wdata    (al_wdata),
    .ldata    (al_ldata),
    .misalign (al_mis)
  );

  // Next-state logic. Pulse outputs default low; everything else holds.
  // The timeout compares against TIMEOUT-1 because the abort happens on the
  // edge where the count would reach TIMEOUT, keeping mem_req up for exactly
  // TIMEOUT cycles. An ack in that last cycle is checked first and wins.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    f3_d        = f3_q;
    addr_lo_d   = addr_lo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    rf_we_d     = 1'b0;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!is_mem_op) begin
            rf_we_d    = (ex_rd != 5'd0);
            rf_waddr_d = ex_rd;
            rf_wdata_d = ex_result;
          end else if (al_mis) begin
            misalign_d = 1'b1;
          end else begin
            state_d     = ST_MEM;
            cnt_d       = '0;
            rd_d        = ex_rd;
            f3_d        = ex_funct3;
            addr_lo_d   = ex_result[1:0];
            mem_req_d   = 1'b1;
            mem_we_d    = ex_is_store;
            mem_addr_d  = {ex_result[31:2], 2'b00};
            mem_be_d    = al_be;
            mem_wdata_d = al_wdata;
          end
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_WB;
            rf_we_d    = (rd_q != 5'd0);
            rf_waddr_d = rd_q;
            rf_wdata_d = al_ldata;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; async reset abandons any access at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rd_q        <= 5'd0;
      f3_q        <= 3'd0;
      addr_lo_q   <= 2'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      rf_waddr_q  <= 5'd0;
      rf_wdata_q  <= 32'h0;
      rf_we_q     <= 1'b0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      f3_q        <= f3_d;
      addr_lo_q   <= addr_lo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      rf_we_q     <= rf_we_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign rf_we     = rf_we_q;
  assign misalign  = misalign_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_lsu_wb_stage.sv
// Self-checking bench for lsu_wb_stage: a table of directed vectors, a few
// hand-written multi-cycle sequences (back-to-back ALU, timeout, reset during
// an access) and randomized ops checked against a transaction-level model.
module tb_lsu_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_sdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_we;
  logic        misalign;
  logic        bus_err;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    bit          isLoad;
    bit          isStore;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          waitCycles;
    bit          expMis;
    logic [3:0]  expBe;
    bit          expRfWe;
    logic [31:0] expRf;
  } vecT;

  vecT vecs[14];

  lsu_wb_stage #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_rd       (ex_rd),
    .ex_result   (ex_result),
    .ex_is_load  (ex_is_load),
    .ex_is_store (ex_is_store),
    .ex_funct3   (ex_funct3),
    .ex_sdata    (ex_sdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .rf_we       (rf_we),
    .misalign    (misalign),
    .bus_err     (bus_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Safety net in case something stalls the whole run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one cycle; outputs are then observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model (access-level arithmetic) ----------------
  function automatic int sizeOf(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit modelMis(input logic [2:0] f3, input logic [31:0] addr);
    return (int'(addr % 32'd4) % sizeOf(f3)) != 0;
  endfunction

  function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] addr);
    int         s;
    int         off;
    logic [7:0] m;
    s   = sizeOf(f3);
    off = int'(addr % 32'd4);
    m   = 8'(((1 << s) - 1) << off);
    return m[3:0];
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] rdata);
    longint unsigned v;
    int              s;
    int              off;
    s   = sizeOf(f3);
    off = int'(addr % 32'd4);
    v   = (64'(rdata) >> (8 * off)) & ((64'd1 << (8 * s)) - 64'd1);
    if (s < 4 && f3 < 3'b100 && v >= (64'd1 << (8 * s - 1)))
      v = v - (64'd1 << (8 * s));
    return 32'(v);
  endfunction

  function automatic logic [31:0] laneMask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++)
      if (be[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  // Drive one op and follow it to completion, checking each cycle of interest.
  task automatic applyStimulus(input vecT v, input string tag);
    bit          isMem;
    int          off;
    logic [31:0] mask;
    isMem = v.isLoad | v.isStore;
    off   = int'(v.addr % 32'd4);
    mask  = laneMask(v.expBe);

    ex_valid    = 1'b1;
    ex_rd       = v.rd;
    ex_result   = v.addr;
    ex_is_load  = v.isLoad;
    ex_is_store = v.isStore;
    ex_funct3   = v.f3;
    ex_sdata    = v.sdata;
    checkOutput({tag, " ex_ready before accept"}, ex_ready, 1);
    step();
    ex_valid    = 1'b0;
    ex_is_load  = 1'b0;
    ex_is_store = 1'b0;

    if (!isMem) begin
      checkOutput({tag, " alu rf_we"}, rf_we, v.expRfWe);
      if (v.expRfWe) begin
        checkOutput({tag, " alu rf_waddr"}, rf_waddr, v.rd);
        checkOutput({tag, " alu rf_wdata"}, rf_wdata, v.expRf);
      end
      checkOutput({tag, " alu mem_req"}, mem_req, 0);
      checkOutput({tag, " alu misalign"}, misalign, 0);
    end else if (v.expMis) begin
      checkOutput({tag, " misalign pulse"}, misalign, 1);
      checkOutput({tag, " misalign mem_req"}, mem_req, 0);
      checkOutput({tag, " misalign rf_we"}, rf_we, 0);
      step();
      checkOutput({tag, " misalign pulse end"}, misalign, 0);
      checkOutput({tag, " misalign mem_req later"}, mem_req, 0);
      checkOutput({tag, " misalign ex_ready"}, ex_ready, 1);
    end else begin
      checkOutput({tag, " mem_req"}, mem_req, 1);
      checkOutput({tag, " mem_addr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
      checkOutput({tag, " mem_be"}, mem_be, v.expBe);
      checkOutput({tag, " mem_we"}, mem_we, v.isStore);
      checkOutput({tag, " ex_ready in MEM"}, ex_ready, 0);
      if (v.isStore)
        checkOutput({tag, " mem_wdata lanes"}, mem_wdata & mask, (v.sdata << (8 * off)) & mask);
      for (int i = 0; i < v.waitCycles; i++) begin
        step();
        checkOutput({tag, " mem_req held"}, mem_req, 1);
      end
      mem_ack   = 1'b1;
      mem_rdata = v.rdata;
      step();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      checkOutput({tag, " mem_req after ack"}, mem_req, 0);
      checkOutput({tag, " rf_we after ack"}, rf_we, v.expRfWe);
      if (v.expRfWe) begin
        checkOutput({tag, " rf_waddr"}, rf_waddr, v.rd);
        checkOutput({tag, " rf_wdata"}, rf_wdata, v.expRf);
      end
      if (!v.isStore) begin
        checkOutput({tag, " ex_ready in WB"}, ex_ready, 0);
        step();
      end
      checkOutput({tag, " rf_we idle"}, rf_we, 0);
      checkOutput({tag, " ex_ready back"}, ex_ready, 1);
    end
  endtask

  // ---------------- test body ----------------
  initial begin
    vecT  v;
    int   kind;
    int   cnt;

    rst_n       = 1'b1;
    ex_valid    = 1'b0;
    ex_rd       = 5'd0;
    ex_result   = 32'h0;
    ex_is_load  = 1'b0;
    ex_is_store = 1'b0;
    ex_funct3   = 3'd0;
    ex_sdata    = 32'h0;
    mem_ack     = 1'b0;
    mem_rdata   = 32'h0;

    // Directed vectors: isLoad, isStore, f3, rd, addr, sdata, rdata, wait,
    // expMis, expBe, expRfWe, expRf
    vecs[0]  = '{0, 0, 3'b000, 5'd7,  32'h0000_0000 | 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 0, 4'b0000, 1, 32'hDEAD_BEEF};
    vecs[1]  = '{1, 0, 3'b000, 5'd10, 32'h0000_0103, 32'h0, 32'h80FF_0000, 3, 0, 4'b1000, 1, 32'hFFFF_FF80};
    vecs[2]  = '{1, 0, 3'b100, 5'd11, 32'h0000_0103, 32'h0, 32'h80FF_0000, 3, 0, 4'b1000, 1, 32'h0000_0080};
    vecs[3]  = '{0, 1, 3'b001, 5'd3,  32'h0000_0202, 32'h0000_BEEF, 32'h0, 2, 0, 4'b1100, 0, 32'h0};
    vecs[4]  = '{1, 0, 3'b010, 5'd12, 32'h0000_0301, 32'h0, 32'h0, 0, 1, 4'b0000, 0, 32'h0};
    vecs[5]  = '{1, 0, 3'b001, 5'd13, 32'h0000_0402, 32'h0, 32'h8001_1234, 0, 0, 4'b1100, 1, 32'hFFFF_8001};
    vecs[6]  = '{1, 0, 3'b101, 5'd13, 32'h0000_0402, 32'h0, 32'h8001_1234, 1, 0, 4'b1100, 1, 32'h0000_8001};
    vecs[7]  = '{1, 0, 3'b010, 5'd14, 32'h0000_0500, 32'h0, 32'hCAFE_F00D, 15, 0, 4'b1111, 1, 32'hCAFE_F00D};
    vecs[8]  = '{1, 0, 3'b000, 5'd0,  32'h0000_0601, 32'h0, 32'h0000_7F00, 1, 0, 4'b0010, 0, 32'h0};
    vecs[9]  = '{1, 1, 3'b010, 5'd4,  32'h0000_0700, 32'h1122_3344, 32'h0, 0, 0, 4'b1111, 0, 32'h0};
    vecs[10] = '{1, 0, 3'b011, 5'd5,  32'h0000_0802, 32'h0, 32'h0, 0, 1, 4'b0000, 0, 32'h0};
    vecs[11] = '{0, 1, 3'b000, 5'd6,  32'h0000_0901, 32'h0000_12A5, 32'h0, 4, 0, 4'b0010, 0, 32'h0};
    vecs[12] = '{1, 0, 3'b001, 5'd8,  32'h0000_0A01, 32'h0, 32'h0, 0, 1, 4'b0000, 0, 32'h0};
    vecs[13] = '{1, 0, 3'b110, 5'd15, 32'h0000_0B00, 32'h0, 32'h89AB_CDEF, 2, 0, 4'b1111, 1, 32'h89AB_CDEF};

    // Reset
    #2 rst_n = 1'b0;
    step();
    step();
    checkOutput("reset ex_ready", ex_ready, 1);
    checkOutput("reset mem_req", mem_req, 0);
    checkOutput("reset rf_we", rf_we, 0);
    checkOutput("reset mem_addr", mem_addr, 0);
    checkOutput("reset misalign", misalign, 0);
    checkOutput("reset bus_err", bus_err, 0);
    rst_n = 1'b1;
    step();

    // Back-to-back ALU ops
    ex_valid = 1'b1; ex_rd = 5'd5; ex_result = 32'h0000_1234;
    step();
    ex_rd = 5'd6; ex_result = 32'h0000_ABCD;
    checkOutput("b2b first rf_we", rf_we, 1);
    checkOutput("b2b first rf_waddr", rf_waddr, 5);
    checkOutput("b2b first rf_wdata", rf_wdata, 32'h1234);
    checkOutput("b2b ex_ready", ex_ready, 1);
    step();
    ex_valid = 1'b0;
    checkOutput("b2b second rf_we", rf_we, 1);
    checkOutput("b2b second rf_waddr", rf_waddr, 6);
    checkOutput("b2b second rf_wdata", rf_wdata, 32'hABCD);
    step();
    checkOutput("b2b drain rf_we", rf_we, 0);
    ex_valid = 1'b1; ex_rd = 5'd0; ex_result = 32'h55;
    step();
    ex_valid = 1'b0;
    checkOutput("alu rd0 rf_we", rf_we, 0);
    step();
    checkOutput("alu rd0 rf_we later", rf_we, 0);

    // Directed table
    for (int i = 0; i < 14; i++)
      applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Timeout: load that never gets an ack
    ex_valid = 1'b1; ex_rd = 5'd9; ex_result = 32'h0000_0C00;
    ex_is_load = 1'b1; ex_funct3 = 3'b010;
    step();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    cnt = 0;
    while (mem_req === 1'b1 && cnt < 40) begin
      cnt++;
      checkOutput("timeout no early bus_err", bus_err, 0);
      step();
    end
    checkOutput("timeout mem_req cycles", cnt, 16);
    checkOutput("timeout bus_err pulse", bus_err, 1);
    checkOutput("timeout ex_ready", ex_ready, 1);
    checkOutput("timeout rf_we", rf_we, 0);
    step();
    checkOutput("timeout bus_err end", bus_err, 0);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 1'b0;
    checkOutput("late ack mem_req", mem_req, 0);
    checkOutput("late ack rf_we", rf_we, 0);
    step();
    checkOutput("late ack rf_we later", rf_we, 0);

    // Reset in the middle of an access
    ex_valid = 1'b1; ex_rd = 5'd8; ex_result = 32'h0000_0D04;
    ex_is_load = 1'b1; ex_funct3 = 3'b010;
    step();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    checkOutput("rst-mid mem_req up", mem_req, 1);
    step();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst-mid mem_req async drop", mem_req, 0);
    checkOutput("rst-mid mem_addr", mem_addr, 0);
    checkOutput("rst-mid mem_be", mem_be, 0);
    checkOutput("rst-mid ex_ready", ex_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("post-rst ex_ready", ex_ready, 1);
    checkOutput("post-rst mem_req", mem_req, 0);
    checkOutput("post-rst rf_we", rf_we, 0);
    checkOutput("post-rst rf_wdata", rf_wdata, 0);
    checkOutput("post-rst mem_wdata", mem_wdata, 0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checkOutput("post-rst ack rf_we", rf_we, 0);

    // Randomized ops against the model
    for (int n = 0; n < 60; n++) begin
      kind      = $urandom_range(0, 3);
      v.isLoad  = (kind == 1 || kind == 3);
      v.isStore = (kind == 2 || kind == 3);
      v.f3      = 3'($urandom_range(0, 7));
      v.rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      v.addr    = $urandom;
      if ($urandom_range(0, 1) == 1) v.addr = v.addr & 32'hFFFF_FFFC;
      v.sdata   = $urandom;
      v.rdata   = $urandom;
      v.waitCycles = $urandom_range(0, 15);
      v.expMis  = (kind != 0) && modelMis(v.f3, v.addr);
      v.expBe   = modelBe(v.f3, v.addr);
      v.expRfWe = (v.rd != 5'd0) && !v.expMis && (kind == 0 || kind == 1);
      v.expRf   = (kind == 0) ? v.addr : modelLoad(v.f3, v.addr, v.rdata);
      applyStimulus(v, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 2) == 0) begin
        // Idle gap, possibly with a stray ack that must be ignored.
        mem_ack = 1'($urandom_range(0, 1));
        step();
        mem_ack = 1'b0;
        checkOutput($sformatf("rnd%0d gap mem_req", n), mem_req, 0);
        checkOutput($sformatf("rnd%0d gap rf_we", n), rf_we, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
